// File: rtl/hit_judge.sv
// hit_judge: four-lane rhythm-game judge. Each lane keeps a three-step note
// window, turns key rising edges into PERFECT/GOOD judgements, flags notes
// that age out as MISS, and the top accumulates score, combo and max combo.

// Per-lane note window and judgement; strobes are registered, the *_nxt
// copies feed the shared score/combo arithmetic in the same cycle.
module hit_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic beat,
  input  logic note,
  input  logic press,
  output logic perfect,
  output logic good,
  output logic miss,
  output logic perfect_nxt,
  output logic good_nxt,
  output logic miss_nxt
);
  logic [2:0] win, win_c, win_n;

  // Judge the pre-shift window, clear the consumed note, then shift on a beat.
  always_comb begin
    perfect_nxt = press & win[1];
    good_nxt    = press & ~win[1] & (win[2] | win[0]);
    win_c       = win;
    if (perfect_nxt)          win_c[1] = 1'b0;
    else if (good_nxt & win[2]) win_c[2] = 1'b0;
    else if (good_nxt)        win_c[0] = 1'b0;
    miss_nxt = beat & win_c[2];
    win_n    = beat ? {win_c[1:0], note} : win_c;
  end

  // Window and strobe registers; clr empties the lane outside a running song.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win     <= '0;
      perfect <= 1'b0;
      good    <= 1'b0;
      miss    <= 1'b0;
    end else if (clr) begin
      win     <= '0;
      perfect <= 1'b0;
      good    <= 1'b0;
      miss    <= 1'b0;
    end else begin
      win     <= win_n;
      perfect <= perfect_nxt;
      good    <= good_nxt;
      miss    <= miss_nxt;
    end
  end
endmodule

module hit_judge #(
  parameter int PERFECT_PTS = 3,
  parameter int GOOD_PTS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_active,
  input  logic        beat_pulse,
  input  logic [3:0]  chart_data,
  input  logic [3:0]  key_press,
  output logic [3:0]  hit_perfect,
  output logic [3:0]  hit_good,
  output logic [3:0]  hit_miss,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo
);
  localparam int NUM_LANES = 4;

  logic                 game_prev;
  logic [NUM_LANES-1:0] key_prev;
  logic                 start, run;
  logic [NUM_LANES-1:0] press_ev;
  logic [NUM_LANES-1:0] p_nxt, g_nxt, m_nxt;
  logic [2:0]           pc, gc;
  logic [18:0]          score_sum;
  logic [15:0]          score_n;
  logic [8:0]           combo_sum;
  logic [7:0]           combo_n;

  // Judging only runs from the second active cycle on; the start cycle clears.
  assign start    = game_active & ~game_prev;
  assign run      = game_active & game_prev;
  assign press_ev = key_press & ~key_prev & {NUM_LANES{run}};

  // Edge registers track inputs continuously so a key held across start
  // does not count as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_prev <= 1'b0;
      key_prev  <= '0;
    end else begin
      game_prev <= game_active;
      key_prev  <= key_press;
    end
  end

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      hit_lane u_lane (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (~run),
        .beat        (beat_pulse & run),
        .note        (chart_data[l]),
        .press       (press_ev[l]),
        .perfect     (hit_perfect[l]),
        .good        (hit_good[l]),
        .miss        (hit_miss[l]),
        .perfect_nxt (p_nxt[l]),
        .good_nxt    (g_nxt[l]),
        .miss_nxt    (m_nxt[l])
      );
    end
  endgenerate

  // Hit counts and saturating next values for score and combo.
  always_comb begin
    pc = '0;
    gc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pc = pc + 3'(p_nxt[i]);
      gc = gc + 3'(g_nxt[i]);
    end
    score_sum = {3'b000, score} + 19'(PERFECT_PTS * pc) + 19'(GOOD_PTS * gc);
    score_n   = (score_sum > 19'd65535) ? 16'hFFFF : score_sum[15:0];
    combo_sum = {1'b0, combo} + 9'(pc) + 9'(gc);
    if (|m_nxt)                  combo_n = 8'd0;
    else if (combo_sum > 9'd255) combo_n = 8'd255;
    else                         combo_n = combo_sum[7:0];
  end

  // Score state: cleared at game start, held while the game is stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else if (start) begin
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else if (run) begin
      score     <= score_n;
      combo     <= combo_n;
      max_combo <= (combo_n > max_combo) ? combo_n : max_combo;
    end
  end
endmodule
